// File: rtl/seq_div_pkg.sv
// Purpose : shared types and constants for the seq_div radix-2 restoring divider.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default widths, saturated quotient used for dbz/ovf results.
package seq_div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    // Saturated quotient returned on divide-by-zero or overflow. Kept wide and
    // sliced by the user so any WIDTH up to 64 can share the one constant.
    localparam int                 SAT_MAX_W = 64;
    localparam logic [SAT_MAX_W-1:0] QUOT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Purpose : start/busy/done handshake and operand/result bundle between ALU control and seq_div.
// Latency : n/a (wiring only).
// Backpressure: none; master may only launch a division when the divider is idle or signalling done.
// Modports: master = ALU control (drives start/operands), slave = divider (drives busy/done/results/flags).
interface seq_div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 dbz;
    logic                 ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz, ovf
    );
endinterface

// File: rtl/seq_div_step.sv
// Purpose : one combinational restoring-division step (shift in one dividend bit, trial subtract).
// Latency : combinational.
// Backpressure: none.
// Ports   : pr (partial remainder, < divisor), bit_in (next dividend bit), divisor -> pr_next, q_bit.
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pr,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] pr_next,
    output logic             q_bit
);
    // The shifted value is WIDTH+1 bits; its top bit is the carry out of pr.
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] diff;

    assign shifted = {pr, bit_in};

    // Trial subtraction at WIDTH+1 bits on the low part only. If the carry bit
    // is set the shifted value is >= 2^WIDTH > divisor, so the subtraction must
    // succeed; because pr < divisor the true difference is still < 2^WIDTH and
    // equals the low WIDTH bits of the wrapped difference.
    assign {borrow, diff} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divisor};

    assign q_bit   = shifted[WIDTH] | ~borrow;
    assign pr_next = q_bit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_div.sv
// Purpose : iterative radix-2 restoring divider, 2*WIDTH-bit dividend / WIDTH-bit divisor -> quotient, remainder.
// Latency : done after edge T+WIDTH+1 for a start sampled at edge T; dbz/ovf (and early-out) results after edge T+1.
// Backpressure: one division in flight; start is ignored unless idle, next start accepted in the done cycle.
// Ports   : clk, rst_n (async active-low), bus (seq_div_if.slave: start/dividend/divisor in;
//           busy/done/quotient/remainder/dbz/ovf out). Optional macro SEQ_DIV_EARLY_OUT_EN finishes
//           dividend < divisor cases at edge T+1 with identical results.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_div_if.slave bus
);
    localparam logic [WIDTH-1:0] SAT = QUOT_SAT[WIDTH-1:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pr_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             done_q, dbz_q, ovf_q;

    // A short-path result (dbz, ovf, early-out) waits one cycle in IDLE so that
    // done lands after edge T+1 without the divider ever looking busy.
    logic             quick_q, qk_dbz_q, qk_ovf_q;

    logic [WIDTH-1:0] hi, lo;
    logic             is_dbz, is_ovf, is_early, quick_take, accept;
    logic [WIDTH-1:0] step_pr;
    logic             step_q;

    assign hi = bus.dividend[2*WIDTH-1:WIDTH];
    assign lo = bus.dividend[WIDTH-1:0];

    assign is_dbz = (bus.divisor == '0);
    // Upper half >= divisor means the quotient cannot fit in WIDTH bits.
    assign is_ovf = !is_dbz && (hi >= bus.divisor);
`ifdef SEQ_DIV_EARLY_OUT_EN
    assign is_early = !is_dbz && (hi == '0) && (lo < bus.divisor);
`else
    assign is_early = 1'b0;
`endif
    assign quick_take = is_dbz | is_ovf | is_early;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .pr      (pr_q),
        .bit_in  (sh_q[WIDTH-1]),
        .divisor (div_q),
        .pr_next (step_pr),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        bus.busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The cycle holding a pending short-path result is not idle for new work.
                accept = bus.start && !quick_q;
                if (accept && !quick_take) state_d = ST_RUN;
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                bus.busy = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q     <= '0;
            sh_q     <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            quick_q  <= 1'b0;
            qk_dbz_q <= 1'b0;
            qk_ovf_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            quick_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (quick_q) begin
                        quot_q <= sh_q;
                        rem_q  <= pr_q;
                        dbz_q  <= qk_dbz_q;
                        ovf_q  <= qk_ovf_q;
                        done_q <= 1'b1;
                    end else if (accept) begin
                        if (quick_take) begin
                            quick_q  <= 1'b1;
                            qk_dbz_q <= is_dbz;
                            qk_ovf_q <= is_ovf;
                            sh_q     <= (is_dbz | is_ovf) ? SAT : '0;
                            pr_q     <= lo;
                        end else begin
                            pr_q  <= hi;
                            sh_q  <= lo;
                            div_q <= bus.divisor;
                            cnt_q <= CNT_W'(WIDTH);
                        end
                    end
                end
                ST_RUN: begin
                    // Dividend bits leave the top of sh_q as quotient bits enter the bottom.
                    pr_q  <= step_pr;
                    sh_q  <= {sh_q[WIDTH-2:0], step_q};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_FIN: begin
                    quot_q <= sh_q;
                    rem_q  <= pr_q;
                    dbz_q  <= 1'b0;
                    ovf_q  <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_div.sv
// Purpose : self-checking bench for seq_div against an arithmetic reference model.
// Latency : expected done cycle and busy window derived from the operands by the model.
// Backpressure: driver only launches when idle or in the done cycle; one extra start is pulsed mid-run.
`timescale 1ns/1ps
module tb_seq_div;
    import seq_div_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_div_if #(.WIDTH(W)) bus ();

    seq_div #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state shared by driver and checker.
    logic          pending   = 1'b0;
    logic          full_path = 1'b0;
    int            start_at  = 0;
    int            done_at   = 0;
    logic [W-1:0]  exp_q = '0, exp_r = '0;
    logic          exp_dbz = 1'b0, exp_ovf = 1'b0;
    logic [W-1:0]  held_q = '0, held_r = '0;
    logic          held_dbz = 1'b0, held_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division plus the flag rules.
    task automatic model(input logic [63:0] dvd, input logic [W-1:0] dvs,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output logic o, output int lat);
        logic [63:0] qq, rr;
        r = dvd[W-1:0];
        if (dvs == '0) begin
            z = 1'b1; o = 1'b0; q = '1; lat = 1;
        end else if (dvd[63:32] >= dvs) begin
            z = 1'b0; o = 1'b1; q = '1; lat = 1;
        end else begin
            z = 1'b0; o = 1'b0;
            qq = dvd / {32'b0, dvs};
            rr = dvd % {32'b0, dvs};
            q = qq[W-1:0];
            r = rr[W-1:0];
            lat = W + 1;
`ifdef SEQ_DIV_EARLY_OUT_EN
            if (dvd < {32'b0, dvs}) lat = 1;
`endif
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic exp_done, exp_busy;
        if (rst_n) begin
            exp_done = pending && (cyc == done_at);
            exp_busy = pending && full_path && (cyc >= start_at) && (cyc < done_at);
            check("done", {63'b0, bus.done}, {63'b0, exp_done});
            check("busy", {63'b0, bus.busy}, {63'b0, exp_busy});
            if (exp_done) begin
                held_q = exp_q; held_r = exp_r; held_dbz = exp_dbz; held_ovf = exp_ovf;
                pending = 1'b0;
            end else if (pending && cyc > done_at) begin
                pending = 1'b0;
            end
            check("quotient",  {32'b0, bus.quotient},  {32'b0, held_q});
            check("remainder", {32'b0, bus.remainder}, {32'b0, held_r});
            check("dbz", {63'b0, bus.dbz}, {63'b0, held_dbz});
            check("ovf", {63'b0, bus.ovf}, {63'b0, held_ovf});
        end
    end

    // Called just after a negedge while the divider can accept a start.
    task automatic issue(input logic [63:0] dvd, input logic [W-1:0] dvs);
        int lat;
        model(dvd, dvs, exp_q, exp_r, exp_dbz, exp_ovf, lat);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        start_at  = cyc + 1;
        done_at   = cyc + 1 + lat;
        full_path = (lat != 1);
        pending   = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = $urandom;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (!pending) return;
        end
        vectors++;
        errors++;
        $display("FAIL wait_done: no done within 200 cycles, expected at cycle %0d", done_at);
        pending = 1'b0;
    endtask

    // Pin the model to hand-computed values, then run the operation on the DUT.
    task automatic pin(input string name, input logic [63:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input logic eo, input int elat);
        logic [W-1:0] q, r;
        logic z, o;
        int lat;
        model(dvd, dvs, q, r, z, o, lat);
        check({name, "_model_q"},   {32'b0, q}, {32'b0, eq});
        check({name, "_model_r"},   {32'b0, r}, {32'b0, er});
        check({name, "_model_flg"}, {62'b0, z, o}, {62'b0, ez, eo});
        check({name, "_model_lat"}, 64'(lat), 64'(elat));
        issue(dvd, dvs);
        wait_done();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_q"},    {32'b0, bus.quotient},  64'd0);
        check({name, "_r"},    {32'b0, bus.remainder}, 64'd0);
        check({name, "_busy"}, {63'b0, bus.busy}, 64'd0);
        check({name, "_done"}, {63'b0, bus.done}, 64'd0);
        check({name, "_dbz"},  {63'b0, bus.dbz},  64'd0);
        check({name, "_ovf"},  {63'b0, bus.ovf},  64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] dvd;
        logic [W-1:0] dvs;
        int kind, gap, early_lat;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        pin("d100_7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);
        pin("d2p32_3", 64'h0000_0001_0000_0000, 32'd3, 32'h5555_5555, 32'd1, 1'b0, 1'b0, 33);
        pin("dmaxprod", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33);
        pin("dbz", 64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0, 1);
        pin("ovf", 64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1);
`ifdef SEQ_DIV_EARLY_OUT_EN
        early_lat = 1;
`else
        early_lat = 33;
`endif
        pin("early", 64'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0, early_lat);

        // Start pulse mid-run must be ignored.
        issue(64'd100, 32'd7);
        repeat (9) @(negedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 64'h0000_0000_0000_FFFF;
        bus.divisor  = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        // Reset mid-run clears everything without a clock edge.
        issue(64'd123_456_789, 32'd1000);
        repeat (14) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        pending = 1'b0;
        held_q = '0; held_r = '0; held_dbz = 1'b0; held_ovf = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        pin("post_rst", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);

        // Randomized operations, including back-to-back starts in the done cycle.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            dvs  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(1, 255));
            if (dvs == '0) dvs = 32'd1;
            case (kind)
                0: begin dvs = '0; dvd = {$urandom, $urandom}; end
                1: begin
                    dvd[31:0]  = $urandom;
                    dvd[63:32] = (dvs == 32'hFFFF_FFFF) ? dvs : dvs + 32'($urandom_range(0, 3));
                end
                2: dvd = {32'b0, 32'($urandom) % dvs};
                default: begin
                    dvd[31:0]  = $urandom;
                    dvd[63:32] = 32'($urandom) % dvs;
                end
            endcase
            issue(dvd, dvs);
            wait_done();
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
